lcd_fifo_reader: RTL

LCD_FIFO_READER -- requirements
Module: lcd_fifo_reader

---
 rtl/lcd_fifo_reader_pkg.sv | 19 +
 rtl/lcd_timing_gen.sv | 78 +++++++
 rtl/lcd_fifo_reader.sv | 109 ++++++++++
 3 files changed

// File: rtl/lcd_fifo_reader_pkg.sv
// Shared widths and default panel timing for the LCD FIFO reader.
// Defaults describe a 480x272 RGB565 panel.
package lcd_fifo_reader_pkg;

  localparam int PIXEL_W = 16;
  localparam int WORD_W  = 32;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BP     = 43;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 8;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 12;

  localparam logic [PIXEL_W-1:0] DEF_UF_COLOR = 16'h0000;

endpackage

// File: rtl/lcd_timing_gen.sv
// Horizontal/vertical scan counters and the counter-stage timing signals.
// The counters idle at 0 until en is sampled high, then free-run.
module lcd_timing_gen
  import lcd_fifo_reader_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic de,
  output logic hsync,
  output logic vsync,
  output logic first,
  output logic odd,
  output logic fetch
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          running;

  // While not yet running the next position is (0,0), so the very first
  // word is fetched in the cycle before the scan starts.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (running) begin
      if (int'(h_cnt) == H_TOTAL - 1) begin
        if (int'(v_cnt) == V_TOTAL - 1) v_nxt = '0;
        else                            v_nxt = v_cnt + VW'(1);
      end else begin
        h_nxt = h_cnt + HW'(1);
        v_nxt = v_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      running <= 1'b0;
    end else if (!en) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      running <= 1'b0;
    end else begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      running <= 1'b1;
    end
  end

  always_comb begin
    de    = running && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    hsync = !(running && (int'(h_cnt) >= H_ACTIVE + H_FP)
                      && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC));
    vsync = !(running && (int'(v_cnt) >= V_ACTIVE + V_FP)
                      && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC));
    first = running && (h_cnt == '0) && (v_cnt == '0);
    odd   = h_cnt[0];
    fetch = en && (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE) && !h_nxt[0];
  end

endmodule

// File: rtl/lcd_fifo_reader.sv
// Streams two-pixel FIFO words onto a parallel RGB565 LCD bus with fixed
// timing; an empty FIFO never stalls the scan, it substitutes UF_COLOR.
module lcd_fifo_reader
  import lcd_fifo_reader_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter logic [PIXEL_W-1:0] UF_COLOR = DEF_UF_COLOR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               uf_clr,
  output logic               fifo_rd_en,
  input  logic [WORD_W-1:0]  fifo_rd_data,
  input  logic               fifo_rd_empty,
  output logic               lcd_de,
  output logic               lcd_hsync,
  output logic               lcd_vsync,
  output logic [PIXEL_W-1:0] lcd_rgb,
  output logic               frame_start,
  output logic               underflow,
  output logic [15:0]        uf_cnt
);

  logic t_de, t_hsync, t_vsync, t_first, t_odd, t_fetch;
  logic pend_ok;
  logic uf_evt;
  logic [WORD_W-1:0]  hold;
  logic [WORD_W-1:0]  hold_nxt;
  logic [PIXEL_W-1:0] pix;

  lcd_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .de    (t_de),
    .hsync (t_hsync),
    .vsync (t_vsync),
    .first (t_first),
    .odd   (t_odd),
    .fetch (t_fetch)
  );

  assign fifo_rd_en = rst_n && t_fetch && !fifo_rd_empty;
  assign uf_evt     = t_fetch && fifo_rd_empty;

  // A missed fetch poisons the whole word so its odd pixel is UF_COLOR too.
  always_comb begin
    hold_nxt = pend_ok ? fifo_rd_data : {UF_COLOR, UF_COLOR};
    pix      = '0;
    if (t_de) begin
      if (!t_odd) pix = hold_nxt[PIXEL_W-1:0];
      else        pix = hold[WORD_W-1:PIXEL_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_rgb     <= '0;
      frame_start <= 1'b0;
      hold        <= '0;
      pend_ok     <= 1'b0;
    end else if (!en) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_rgb     <= '0;
      frame_start <= 1'b0;
      hold        <= '0;
      pend_ok     <= 1'b0;
    end else begin
      lcd_de      <= t_de;
      lcd_hsync   <= t_hsync;
      lcd_vsync   <= t_vsync;
      lcd_rgb     <= pix;
      frame_start <= t_first;
      pend_ok     <= fifo_rd_en;
      if (t_de && !t_odd) hold <= hold_nxt;
    end
  end

  // Clear has priority over a simultaneous underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      uf_cnt    <= '0;
    end else if (uf_clr) begin
      underflow <= 1'b0;
      uf_cnt    <= '0;
    end else if (uf_evt) begin
      underflow <= 1'b1;
      if (uf_cnt != 16'hFFFF) uf_cnt <= uf_cnt + 16'd1;
    end
  end

endmodule
